// File: rtl/ysyx_23060236_icache_sa.sv
// Set-associative instruction cache with an integrated line-refill FSM and fence.i invalidation.
// Optional hit/miss performance counters are enabled by defining ICACHE_PERF_EN.
module ysyx_23060236_icache_sa #(
  parameter int unsigned ADDR_LEN   = 32,
  parameter int unsigned DATA_LEN   = 32,
  parameter int unsigned OFFSET_LEN = 5,
  parameter int unsigned INDEX_LEN  = 4,
  parameter int unsigned NUM_WAYS   = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_LEN-1:0] req_addr,
  output logic                resp_valid,
  output logic [DATA_LEN-1:0] resp_data,
  output logic                mem_arvalid,
  input  logic                mem_arready,
  output logic [ADDR_LEN-1:0] mem_araddr,
  input  logic                mem_rvalid,
  output logic                mem_rready,
  input  logic [DATA_LEN-1:0] mem_rdata,
`ifdef ICACHE_PERF_EN
  output logic [31:0]         perf_hit_cnt,
  output logic [31:0]         perf_miss_cnt,
`endif
  input  logic                inst_fencei
);

  localparam int unsigned BLOCK_WORDS = 1 << (OFFSET_LEN - 2);
  localparam int unsigned NUM_SETS    = 1 << INDEX_LEN;
  localparam int unsigned TAG_LEN     = ADDR_LEN - INDEX_LEN - OFFSET_LEN;
  localparam int unsigned WORD_W      = OFFSET_LEN - 2;
  localparam int unsigned WAY_W       = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StMissAr,
    StRefill,
    StResp
  } state_e;

  state_e                                 state_q, state_d;
  logic [ADDR_LEN-1:0]                    addr_q, addr_d;
  logic [WAY_W-1:0]                       victim_q, victim_d;
  logic [WORD_W-1:0]                      cnt_q, cnt_d;
  logic                                   fence_pend_q, fence_pend_d;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0]      valid_q, valid_d;
  logic [NUM_SETS-1:0][WAY_W-1:0]         rr_q, rr_d;

  logic [DATA_LEN-1:0] data_q [NUM_SETS][NUM_WAYS][BLOCK_WORDS];
  logic [TAG_LEN-1:0]  tag_q  [NUM_SETS][NUM_WAYS];

  logic [TAG_LEN-1:0]   tag_s;
  logic [INDEX_LEN-1:0] idx_s;
  logic [WORD_W-1:0]    off_s;
  logic                 hit;
  logic [WAY_W-1:0]     hit_way;
  logic [WAY_W-1:0]     vic_sel;
  logic                 vic_found;
  logic                 data_we;
  logic                 fill_done;
  logic                 unused_addr_lo;

  assign tag_s          = addr_q[ADDR_LEN-1 -: TAG_LEN];
  assign idx_s          = addr_q[OFFSET_LEN +: INDEX_LEN];
  assign off_s          = addr_q[2 +: WORD_W];
  assign unused_addr_lo = ^addr_q[1:0];

  // Tags are unique within a set by construction, so the first match is the only one.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!hit && valid_q[idx_s][w] && (tag_q[idx_s][w] == tag_s)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Lowest-numbered invalid way wins; otherwise fall back to the set's round-robin pointer.
  always_comb begin
    vic_found = 1'b0;
    vic_sel   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!vic_found && !valid_q[idx_s][w]) begin
        vic_found = 1'b1;
        vic_sel   = WAY_W'(w);
      end
    end
    if (!vic_found) begin
      vic_sel = rr_q[idx_s];
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    victim_d     = victim_q;
    cnt_d        = cnt_q;
    fence_pend_d = fence_pend_q;
    valid_d      = valid_q;
    rr_d         = rr_q;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_data    = '0;
    mem_arvalid  = 1'b0;
    mem_rready   = 1'b0;
    mem_araddr   = {tag_s, idx_s, {OFFSET_LEN{1'b0}}};
    data_we      = 1'b0;
    fill_done    = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          state_d = StLookup;
        end
      end
      StLookup: begin
        if (hit) begin
          resp_valid = 1'b1;
          resp_data  = data_q[idx_s][hit_way][off_s];
          state_d    = StIdle;
        end else begin
          victim_d = vic_sel;
          state_d  = StMissAr;
        end
      end
      StMissAr: begin
        mem_arvalid = 1'b1;
        if (mem_arready) begin
          cnt_d   = '0;
          state_d = StRefill;
        end
      end
      StRefill: begin
        mem_rready = 1'b1;
        if (mem_rvalid) begin
          data_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == WORD_W'(BLOCK_WORDS - 1)) begin
            fill_done = 1'b1;
            state_d   = StResp;
          end
        end
      end
      StResp: begin
        resp_valid = 1'b1;
        resp_data  = data_q[idx_s][victim_q][off_s];
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (fill_done) begin
      if (!fence_pend_q) begin
        valid_d[idx_s][victim_q] = 1'b1;
      end
      rr_d[idx_s] = (rr_q[idx_s] == WAY_W'(NUM_WAYS - 1)) ? '0 : rr_q[idx_s] + 1'b1;
    end

    // A fence seen while a fill is in flight must keep that line from becoming valid.
    if (inst_fencei && ((state_q == StMissAr) || (state_q == StRefill))) begin
      fence_pend_d = 1'b1;
    end
    if (state_d == StIdle) begin
      fence_pend_d = 1'b0;
    end

    // Applied last so a fence on the final beat overrides the valid set.
    if (inst_fencei) begin
      valid_d = '0;
      rr_d    = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      victim_q     <= '0;
      cnt_q        <= '0;
      fence_pend_q <= 1'b0;
      valid_q      <= '0;
      rr_q         <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      victim_q     <= victim_d;
      cnt_q        <= cnt_d;
      fence_pend_q <= fence_pend_d;
      valid_q      <= valid_d;
      rr_q         <= rr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && data_we) begin
      data_q[idx_s][victim_q][cnt_q] <= mem_rdata;
    end
    if (!reset && fill_done) begin
      tag_q[idx_s][victim_q] <= tag_s;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == StLookup) begin
      if (hit) begin
        hit_cnt_d = hit_cnt_q + 32'd1;
      end else begin
        miss_cnt_d = miss_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign perf_hit_cnt  = hit_cnt_q;
  assign perf_miss_cnt = miss_cnt_q;
`endif

endmodule
